// File: rtl/router_pkg.sv
// Shared constants for the 1x3 router datapath slice.
package router_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 2;

  // Address value reserved as invalid in the header's low field
  localparam logic [DEF_ADDR_W-1:0] ADDR_INVALID = '1;

  // Payload length field of the header byte
  localparam int LEN_MSB = DEF_DATA_W - 1;
  localparam int LEN_LSB = DEF_ADDR_W;

endpackage

// File: rtl/router_pkt_reg_if.sv
// Source/FSM/FIFO-side signals of the router packet register.
// Optional len_err output exists when ROUTER_REG_LEN_CHK_EN is defined.
interface router_pkt_reg_if
  import router_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
);

  logic              pkt_vld;
  logic [DATA_W-1:0] data_in;
  logic              fifo_full;
  logic              detect_addr;
  logic              lfd_state;
  logic              ld_state;
  logic              laf_state;
  logic              full_state;
  logic              rst_int_reg;
  logic [DATA_W-1:0] dout;
  logic              parity_done;
  logic              low_pkt_vld;
  logic              err;
`ifdef ROUTER_REG_LEN_CHK_EN
  logic              len_err;
`endif

  modport master (
    output pkt_vld, data_in, fifo_full, detect_addr, lfd_state, ld_state,
           laf_state, full_state, rst_int_reg,
`ifdef ROUTER_REG_LEN_CHK_EN
    input  len_err,
`endif
    input  dout, parity_done, low_pkt_vld, err
  );

  modport slave (
    input  pkt_vld, data_in, fifo_full, detect_addr, lfd_state, ld_state,
           laf_state, full_state, rst_int_reg,
`ifdef ROUTER_REG_LEN_CHK_EN
    output len_err,
`endif
    output dout, parity_done, low_pkt_vld, err
  );

endinterface

// File: rtl/router_parity_acc.sv
// Running XOR parity of header+payload against the received parity byte.
// With ROUTER_REG_LEN_CHK_EN defined, also checks payload count against header length.
module router_parity_acc
  import router_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              detect_addr,
  input  logic              lfd_state,
  input  logic              ld_state,
  input  logic              pkt_vld,
  input  logic              parity_done,
  input  logic [DATA_W-1:0] data_in,
  input  logic [DATA_W-1:0] hdr_q,
`ifdef ROUTER_REG_LEN_CHK_EN
  output logic              len_err,
`endif
  output logic              err
);

  logic [DATA_W-1:0] int_par;
  logic [DATA_W-1:0] ext_par;

  // Payload bytes count once on arrival, whether they go to dout or the hold byte
  always_ff @(posedge clk) begin
    if (!rstn) begin
      int_par <= '0;
      ext_par <= '0;
    end else begin
      if (detect_addr)
        int_par <= '0;
      else if (lfd_state)
        int_par <= int_par ^ hdr_q;
      else if (ld_state && pkt_vld)
        int_par <= int_par ^ data_in;

      if (detect_addr)
        ext_par <= '0;
      else if (ld_state && !pkt_vld)
        ext_par <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn)
      err <= 1'b0;
    else if (lfd_state)
      err <= 1'b0;
    else if (parity_done)
      err <= (int_par != ext_par);
  end

`ifdef ROUTER_REG_LEN_CHK_EN
  localparam int LEN_W = DATA_W - ADDR_W;

  logic [LEN_W-1:0] pay_cnt;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      pay_cnt <= '0;
      len_err <= 1'b0;
    end else begin
      if (detect_addr)
        pay_cnt <= '0;
      else if (ld_state && pkt_vld)
        pay_cnt <= pay_cnt + 1'b1;

      if (lfd_state)
        len_err <= 1'b0;
      else if (parity_done)
        len_err <= (pay_cnt != hdr_q[DATA_W-1:ADDR_W]);
    end
  end
`endif

endmodule

// File: rtl/router_pkt_reg.sv
// Router datapath register: header capture, FIFO-full hold byte, FIFO write data, parity status.
// Define ROUTER_REG_LEN_CHK_EN to add the payload length check output len_err.
module router_pkt_reg
  import router_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input logic             clk,
  input logic             rstn,
  router_pkt_reg_if.slave bus
);

  logic [DATA_W-1:0] hdr_q;
  logic [DATA_W-1:0] ffb_q;
  logic [DATA_W-1:0] dout_q;
  logic              low_pkt_vld_q;
  logic              parity_done_q;
  logic              hdr_addr_ok;
  logic              unused_full_state;

  // The FSM's fifo_full_state only stalls the source; the byte already sits in ffb_q
  assign unused_full_state = bus.full_state;
  assign hdr_addr_ok       = !(&bus.data_in[ADDR_W-1:0]);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      hdr_q  <= '0;
      ffb_q  <= '0;
      dout_q <= '0;
    end else begin
      if (bus.detect_addr && bus.pkt_vld && hdr_addr_ok)
        hdr_q <= bus.data_in;

      if (bus.ld_state && bus.fifo_full)
        ffb_q <= bus.data_in;

      if (bus.lfd_state)
        dout_q <= hdr_q;
      else if (bus.ld_state && !bus.fifo_full)
        dout_q <= bus.data_in;
      else if (bus.laf_state)
        dout_q <= ffb_q;
    end
  end

  // A parity byte that met a full FIFO completes only once it is drained in load_after_full
  always_ff @(posedge clk) begin
    if (!rstn) begin
      low_pkt_vld_q <= 1'b0;
      parity_done_q <= 1'b0;
    end else begin
      if (bus.rst_int_reg)
        low_pkt_vld_q <= 1'b0;
      else if (bus.ld_state && !bus.pkt_vld)
        low_pkt_vld_q <= 1'b1;

      if (bus.detect_addr)
        parity_done_q <= 1'b0;
      else if ((bus.ld_state && !bus.fifo_full && !bus.pkt_vld) ||
               (bus.laf_state && low_pkt_vld_q && !parity_done_q))
        parity_done_q <= 1'b1;
    end
  end

  router_parity_acc #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_parity_acc (
    .clk         (clk),
    .rstn        (rstn),
    .detect_addr (bus.detect_addr),
    .lfd_state   (bus.lfd_state),
    .ld_state    (bus.ld_state),
    .pkt_vld     (bus.pkt_vld),
    .parity_done (parity_done_q),
    .data_in     (bus.data_in),
    .hdr_q       (hdr_q),
`ifdef ROUTER_REG_LEN_CHK_EN
    .len_err     (bus.len_err),
`endif
    .err         (bus.err)
  );

  assign bus.dout        = dout_q;
  assign bus.parity_done = parity_done_q;
  assign bus.low_pkt_vld = low_pkt_vld_q;

endmodule

// File: tb/tb_router_pkt_reg.sv
// Directed scenario bench for router_pkt_reg; FSM state decodes are driven directly.
module tb_router_pkt_reg;

  localparam logic [5:0] IDLE = 6'b000000;
  localparam logic [5:0] DET  = 6'b000001;
  localparam logic [5:0] LFD  = 6'b000010;
  localparam logic [5:0] LD   = 6'b000100;
  localparam logic [5:0] LAF  = 6'b001000;
  localparam logic [5:0] FST  = 6'b010000;
  localparam logic [5:0] CPE  = 6'b100000;

  logic clk = 1'b0;
  logic rstn;
  int   compared   = 0;
  int   mismatched = 0;

  router_pkt_reg_if #(.DATA_W(8)) bus ();

  router_pkt_reg #(
    .DATA_W (8),
    .ADDR_W (2)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs, then sample 1 time unit after the edge
  task automatic step(input logic [5:0] st, input logic vld, input logic [7:0] din,
                      input logic full);
    {bus.rst_int_reg, bus.full_state, bus.laf_state, bus.ld_state, bus.lfd_state,
     bus.detect_addr} = st;
    bus.pkt_vld   = vld;
    bus.data_in   = din;
    bus.fifo_full = full;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    step(IDLE, 1'b0, 8'h00, 1'b0);
    step(IDLE, 1'b0, 8'h00, 1'b0);
    compared++; if (bus.dout !== 8'h00) begin mismatched++; $display("[TB] FAIL rst_dout got=%h exp=00", bus.dout); end
    compared++; if (bus.parity_done !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_parity_done got=%b exp=0", bus.parity_done); end
    compared++; if (bus.low_pkt_vld !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_low_pkt_vld got=%b exp=0", bus.low_pkt_vld); end
    compared++; if (bus.err !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_err got=%b exp=0", bus.err); end
`ifdef ROUTER_REG_LEN_CHK_EN
    compared++; if (bus.len_err !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_len_err got=%b exp=0", bus.len_err); end
`endif
    rstn = 1'b1;
  endtask

  // Header 0x11, payload 11 22 33 44, parity 0x55 (11^11^22^33^44)
  task automatic test_normal();
    logic [7:0] pl [4];
    pl = '{8'h11, 8'h22, 8'h33, 8'h44};
    step(DET, 1'b1, 8'h11, 1'b0);
    compared++; if (bus.parity_done !== 1'b0) begin mismatched++; $display("[TB] FAIL norm_pd_det got=%b exp=0", bus.parity_done); end
    step(LFD, 1'b1, 8'h11, 1'b0);
    compared++; if (bus.dout !== 8'h11) begin mismatched++; $display("[TB] FAIL norm_dout_hdr got=%h exp=11", bus.dout); end
    for (int i = 0; i < 4; i++) begin
      step(LD, 1'b1, pl[i], 1'b0);
      compared++; if (bus.dout !== pl[i]) begin mismatched++; $display("[TB] FAIL norm_dout_pl%0d got=%h exp=%h", i, bus.dout, pl[i]); end
    end
    compared++; if (bus.parity_done !== 1'b0) begin mismatched++; $display("[TB] FAIL norm_pd_early got=%b exp=0", bus.parity_done); end
    step(LD, 1'b0, 8'h55, 1'b0);
    compared++; if (bus.parity_done !== 1'b1) begin mismatched++; $display("[TB] FAIL norm_pd got=%b exp=1", bus.parity_done); end
    compared++; if (bus.low_pkt_vld !== 1'b1) begin mismatched++; $display("[TB] FAIL norm_low got=%b exp=1", bus.low_pkt_vld); end
    compared++; if (bus.dout !== 8'h55) begin mismatched++; $display("[TB] FAIL norm_dout_par got=%h exp=55", bus.dout); end
    step(CPE, 1'b0, 8'h55, 1'b0);
    compared++; if (bus.err !== 1'b0) begin mismatched++; $display("[TB] FAIL norm_err got=%b exp=0", bus.err); end
    compared++; if (bus.low_pkt_vld !== 1'b0) begin mismatched++; $display("[TB] FAIL norm_low_clr got=%b exp=0", bus.low_pkt_vld); end
`ifdef ROUTER_REG_LEN_CHK_EN
    compared++; if (bus.len_err !== 1'b0) begin mismatched++; $display("[TB] FAIL norm_len_err got=%b exp=0", bus.len_err); end
`endif
  endtask

  task automatic test_bad_parity();
    logic [7:0] pl [4];
    pl = '{8'h11, 8'h22, 8'h33, 8'h44};
    step(DET, 1'b1, 8'h11, 1'b0);
    step(LFD, 1'b1, 8'h11, 1'b0);
    for (int i = 0; i < 4; i++) step(LD, 1'b1, pl[i], 1'b0);
    step(LD, 1'b0, 8'h54, 1'b0);
    step(CPE, 1'b0, 8'h54, 1'b0);
    compared++; if (bus.err !== 1'b1) begin mismatched++; $display("[TB] FAIL bad_err_cpe got=%b exp=1", bus.err); end
    step(IDLE, 1'b0, 8'h00, 1'b0);
    compared++; if (bus.err !== 1'b1) begin mismatched++; $display("[TB] FAIL bad_err_hold got=%b exp=1", bus.err); end
    step(DET, 1'b1, 8'h11, 1'b0);
    compared++; if (bus.err !== 1'b1) begin mismatched++; $display("[TB] FAIL bad_err_det got=%b exp=1", bus.err); end
    step(LFD, 1'b1, 8'h11, 1'b0);
    compared++; if (bus.err !== 1'b0) begin mismatched++; $display("[TB] FAIL bad_err_lfd got=%b exp=0", bus.err); end
  endtask

  // 0x33 meets a full FIFO, is held through fifo_full_state, then drained from the hold byte
  task automatic test_fifo_full_payload();
    step(DET, 1'b1, 8'h11, 1'b0);
    step(LFD, 1'b1, 8'h11, 1'b0);
    step(LD, 1'b1, 8'h11, 1'b0);
    step(LD, 1'b1, 8'h22, 1'b0);
    compared++; if (bus.dout !== 8'h22) begin mismatched++; $display("[TB] FAIL ffp_dout22 got=%h exp=22", bus.dout); end
    step(LD, 1'b1, 8'h33, 1'b1);
    compared++; if (bus.dout !== 8'h22) begin mismatched++; $display("[TB] FAIL ffp_dout_full got=%h exp=22", bus.dout); end
    step(FST, 1'b1, 8'h33, 1'b1);
    compared++; if (bus.dout !== 8'h22) begin mismatched++; $display("[TB] FAIL ffp_dout_fst got=%h exp=22", bus.dout); end
    step(LAF, 1'b1, 8'h33, 1'b0);
    compared++; if (bus.dout !== 8'h33) begin mismatched++; $display("[TB] FAIL ffp_dout_laf got=%h exp=33", bus.dout); end
    compared++; if (bus.parity_done !== 1'b0) begin mismatched++; $display("[TB] FAIL ffp_pd_laf got=%b exp=0", bus.parity_done); end
    step(LD, 1'b1, 8'h44, 1'b0);
    compared++; if (bus.dout !== 8'h44) begin mismatched++; $display("[TB] FAIL ffp_dout44 got=%h exp=44", bus.dout); end
    step(LD, 1'b0, 8'h55, 1'b0);
    compared++; if (bus.parity_done !== 1'b1) begin mismatched++; $display("[TB] FAIL ffp_pd got=%b exp=1", bus.parity_done); end
    step(CPE, 1'b0, 8'h55, 1'b0);
    compared++; if (bus.err !== 1'b0) begin mismatched++; $display("[TB] FAIL ffp_err got=%b exp=0", bus.err); end
  endtask

  // Header 0x12; parity 0x56 = 12^11^22^33^44, arriving while the FIFO is full
  task automatic test_fifo_full_parity();
    logic [7:0] pl [4];
    pl = '{8'h11, 8'h22, 8'h33, 8'h44};
    step(DET, 1'b1, 8'h12, 1'b0);
    step(LFD, 1'b1, 8'h12, 1'b0);
    compared++; if (bus.dout !== 8'h12) begin mismatched++; $display("[TB] FAIL ffq_dout_hdr got=%h exp=12", bus.dout); end
    for (int i = 0; i < 4; i++) step(LD, 1'b1, pl[i], 1'b0);
    step(LD, 1'b0, 8'h56, 1'b1);
    compared++; if (bus.low_pkt_vld !== 1'b1) begin mismatched++; $display("[TB] FAIL ffq_low got=%b exp=1", bus.low_pkt_vld); end
    compared++; if (bus.parity_done !== 1'b0) begin mismatched++; $display("[TB] FAIL ffq_pd_ld got=%b exp=0", bus.parity_done); end
    compared++; if (bus.dout !== 8'h44) begin mismatched++; $display("[TB] FAIL ffq_dout_hold got=%h exp=44", bus.dout); end
    step(FST, 1'b0, 8'h56, 1'b1);
    compared++; if (bus.parity_done !== 1'b0) begin mismatched++; $display("[TB] FAIL ffq_pd_fst got=%b exp=0", bus.parity_done); end
    step(LAF, 1'b0, 8'h56, 1'b0);
    compared++; if (bus.parity_done !== 1'b1) begin mismatched++; $display("[TB] FAIL ffq_pd_laf got=%b exp=1", bus.parity_done); end
    compared++; if (bus.dout !== 8'h56) begin mismatched++; $display("[TB] FAIL ffq_dout_laf got=%h exp=56", bus.dout); end
    step(CPE, 1'b0, 8'h56, 1'b0);
    compared++; if (bus.low_pkt_vld !== 1'b0) begin mismatched++; $display("[TB] FAIL ffq_low_clr got=%b exp=0", bus.low_pkt_vld); end
    compared++; if (bus.err !== 1'b0) begin mismatched++; $display("[TB] FAIL ffq_err got=%b exp=0", bus.err); end
  endtask

  // Address 3 must not overwrite the previous header (0x12)
  task automatic test_addr_invalid();
    step(DET, 1'b1, 8'h13, 1'b0);
    step(LFD, 1'b1, 8'h13, 1'b0);
    compared++; if (bus.dout !== 8'h12) begin mismatched++; $display("[TB] FAIL addr3_hdr got=%h exp=12", bus.dout); end
  endtask

  task automatic test_reset_mid();
    step(DET, 1'b1, 8'h11, 1'b0);
    step(LFD, 1'b1, 8'h11, 1'b0);
    step(LD, 1'b1, 8'h11, 1'b0);
    step(LD, 1'b1, 8'h22, 1'b0);
    step(LD, 1'b0, 8'h77, 1'b0);
    step(CPE, 1'b0, 8'h77, 1'b0);
    compared++; if (bus.err !== 1'b1) begin mismatched++; $display("[TB] FAIL rmid_err_pre got=%b exp=1", bus.err); end
    rstn = 1'b0;
    step(LD, 1'b0, 8'h99, 1'b0);
    compared++; if (bus.dout !== 8'h00) begin mismatched++; $display("[TB] FAIL rmid_dout got=%h exp=00", bus.dout); end
    compared++; if (bus.err !== 1'b0) begin mismatched++; $display("[TB] FAIL rmid_err got=%b exp=0", bus.err); end
    compared++; if (bus.parity_done !== 1'b0) begin mismatched++; $display("[TB] FAIL rmid_pd got=%b exp=0", bus.parity_done); end
    compared++; if (bus.low_pkt_vld !== 1'b0) begin mismatched++; $display("[TB] FAIL rmid_low got=%b exp=0", bus.low_pkt_vld); end
    rstn = 1'b1;
    step(IDLE, 1'b0, 8'h00, 1'b0);
  endtask

`ifdef ROUTER_REG_LEN_CHK_EN
  // Header length 4 but only 3 payload bytes; parity 0x11 = 11^11^22^33 is correct
  task automatic test_len_chk();
    step(DET, 1'b1, 8'h11, 1'b0);
    step(LFD, 1'b1, 8'h11, 1'b0);
    step(LD, 1'b1, 8'h11, 1'b0);
    step(LD, 1'b1, 8'h22, 1'b0);
    step(LD, 1'b1, 8'h33, 1'b0);
    step(LD, 1'b0, 8'h11, 1'b0);
    step(CPE, 1'b0, 8'h11, 1'b0);
    compared++; if (bus.len_err !== 1'b1) begin mismatched++; $display("[TB] FAIL len_err got=%b exp=1", bus.len_err); end
    compared++; if (bus.err !== 1'b0) begin mismatched++; $display("[TB] FAIL len_par_err got=%b exp=0", bus.err); end
    step(DET, 1'b1, 8'h11, 1'b0);
    step(LFD, 1'b1, 8'h11, 1'b0);
    compared++; if (bus.len_err !== 1'b0) begin mismatched++; $display("[TB] FAIL len_err_lfd got=%b exp=0", bus.len_err); end
  endtask
`endif

  initial begin
    rstn = 1'b0;
    test_reset();
    test_normal();
    test_bad_parity();
    test_fifo_full_payload();
    test_fifo_full_parity();
    test_addr_invalid();
    test_reset_mid();
`ifdef ROUTER_REG_LEN_CHK_EN
    test_len_chk();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/router_pkt_reg.md
Name: router_pkt_reg

Overview:
Datapath register stage between the input port and the three output FIFOs of the 1x3 router.
- Driven by the router control FSM's state decodes.
- Captures the header and buffers the byte held off while the FIFO is full.
- Drives the FIFO write data.
- Computes running XOR parity and reports parity_done, low_pkt_vld and a parity error back to the FSM and the host.

Parameters:
DATA_W, 8, packet byte width
ADDR_W, 2, destination address field width, header bits [ADDR_W-1:0]

Ports:
clk  in  1  clock
rstn  in  1  reset, synchronous, active-low
pkt_vld  in  1  source byte valid; deasserts on the cycle carrying the parity byte
data_in  in  DATA_W  source byte
fifo_full  in  1  full flag of the currently addressed FIFO
detect_addr  in  1  FSM in decode_addr
lfd_state  in  1  FSM in load_first_data
ld_state  in  1  FSM in load_data
laf_state  in  1  FSM in load_after_full
full_state  in  1  FSM in fifo_full_state
rst_int_reg  in  1  FSM in check_parity_error
dout  out  DATA_W  FIFO write data
parity_done  out  1  parity byte received
low_pkt_vld  out  1  pkt_vld fell while in load_data
err  out  1  parity mismatch on the last packet

Behaviour:
- All state is flopped on posedge clk. With rstn=0, every register and output is 0.
- hdr_q
  - Loads data_in when detect_addr && pkt_vld && data_in[ADDR_W-1:0] != all-ones (address 3 is invalid).
  - Otherwise holds.
- ffb_q (full-hold byte): loads data_in when ld_state && fifo_full; otherwise holds.
- dout, first match wins; latency is 1 cycle:
  - lfd_state: dout <= hdr_q
  - ld_state && !fifo_full: dout <= data_in
  - laf_state: dout <= ffb_q
  - otherwise: hold
- int_par
  - Cleared on detect_addr.
  - lfd_state: int_par ^= hdr_q.
  - ld_state && pkt_vld: int_par ^= data_in. Each payload byte is counted exactly once, whether it goes to dout or ffb_q.
- ext_par: loads data_in when ld_state && !pkt_vld (the parity byte, full or not); cleared on detect_addr.
- low_pkt_vld
  - rst_int_reg clears it; this has priority.
  - Otherwise set by ld_state && !pkt_vld; otherwise holds.
- parity_done
  - detect_addr clears it; this has priority.
  - Set by ld_state && !fifo_full && !pkt_vld, or by laf_state && low_pkt_vld && !parity_done.
  - Otherwise holds.
- err
  - lfd_state clears it; this has priority.
  - While parity_done=1: err <= (int_par != ext_par).
  - Otherwise holds.
  - err is therefore visible from check_parity_error until the next packet's load_first_data.
- Full stall: the source must hold data_in while the FSM sits in fifo_full_state. full_state affects no datapath register; the byte was already captured in ffb_q.
- Reset mid-packet: rstn=0 zeroes all registers on the next edge, regardless of state inputs. A soft reset is handled by the FSM returning to decode_addr, which clears int_par, ext_par and parity_done.
- Simultaneous events:
  - detect_addr and lfd_state are mutually exclusive by construction.
  - If the FSM violates this, the dout priority order above applies.

Optional Feature:
ROUTER_REG_LEN_CHK_EN
- Defined:
  - Adds output len_err (1 bit) and a payload counter of DATA_W-ADDR_W bits.
  - Counter: cleared on detect_addr; incremented on ld_state && pkt_vld.
  - When parity_done=1: len_err <= (count != hdr_q[DATA_W-1:ADDR_W]).
  - len_err is cleared on lfd_state and on reset.
- Undefined: no len_err port and no counter; the rest of the block is identical.

Decomposition:
- Shared package router_pkg holds:
  - DATA_W and ADDR_W defaults
  - ADDR_INVALID constant (all-ones)
  - header field slice constants: LEN_MSB, LEN_LSB
- One sub-module, router_parity_acc: int_par/ext_par accumulation plus err (and len_err) generation.
- Header, hold-byte and dout registers stay in the top module.

Test Plan:
- Normal packet, fifo_full=0:
  - Stimulus: header 0x11 (len 4, addr 1); payload 0x11,0x22,0x33,0x44; parity byte 0x55.
  - Expected: dout sequence 0x11,0x11,0x22,0x33,0x44; parity_done=1 one cycle after the parity byte; err=0 in check_parity_error.
- Same packet with parity byte 0x54 -> err=1 from check_parity_error; err returns to 0 on the next packet's lfd_state.
- fifo_full during payload:
  - Stimulus: fifo_full=1 on the cycle 0x33 is presented; 0x33 held 2 cycles; then laf_state.
  - Expected: ffb_q=0x33; dout=0x33 after laf_state; final dout stream unchanged; err=0.
- fifo_full on the parity byte:
  - Expected: low_pkt_vld=1; parity_done set in laf_state, not in ld_state; low_pkt_vld cleared in check_parity_error.
- Header 0x13 (address 3) at detect_addr -> hdr_q unchanged. Then rstn=0 mid-payload -> all outputs 0 next cycle.
- With ROUTER_REG_LEN_CHK_EN: header length 4 but 3 payload bytes plus correct parity -> len_err=1, err=0.
